// File: rtl/arith_pkg.sv
// Shared arithmetic package: default operand width, sequencer state type and
// the bit-counter width derived from the default width.
package arith_pkg;

  localparam int USUB_WIDTH = 8;
  localparam int USUB_CNT_W = $clog2(USUB_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsub1.sv
// 1-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow for one bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/usub8_serial.sv
// Bit-serial unsigned subtractor: operands shift LSB-first through one fsub1
// cell, one bit per clock; the result is presented with a valid/ready handshake.
// Optional feature macro: USUB8_SERIAL_SAT_EN clamps the difference to zero
// whenever the final borrow is set (borrow_o still reports 1).
module usub8_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = USUB_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bin_q;
  logic [CNT_W-1:0] cnt;
  logic             d, bout;
  logic [WIDTH-1:0] r_next;

  fsub1 u_fsub1 (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin_q),
    .d    (d),
    .bout (bout)
  );

  // New difference bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  always_comb begin
    r_next = {d, r_sh[WIDTH-1:1]};
  end

  // Sequencer, operand/result shifters and registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bin_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_sh  <= opa_i;
            b_sh  <= opb_i;
            bin_q <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          r_sh  <= r_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          bin_q <= bout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
`ifdef USUB8_SERIAL_SAT_EN
            diff_q <= bout ? '0 : r_next;
`else
            diff_q <= r_next;
`endif
            borrow_q <= bout;
            state    <= DONE;
          end
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags come straight from the state register; no input feeds an output.
  assign ready_o  = (state == IDLE);
  assign valid_o  = (state == DONE);
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

endmodule

// File: tb/tb_usub8_serial.sv
// Self-checking bench for usub8_serial: directed vectors, backpressure,
// mid-operation reset and a randomized back-to-back stream against an
// arithmetic reference model. Honours USUB8_SERIAL_SAT_EN in the model.
module tb_usub8_serial;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] opa_i = '0;
  logic [W-1:0] opb_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] diff_o;
  logic         borrow_o;

  int checks = 0;
  int errors = 0;

  usub8_serial #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .diff_o   (diff_o),
    .borrow_o (borrow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: {borrow, diff} from plain integer arithmetic.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned dv;
    logic        br;
    br = (a < b);
    dv = (int'(a) - int'(b) + (1 << W)) % (1 << W);
`ifdef USUB8_SERIAL_SAT_EN
    if (br) dv = 0;
`endif
    return {br, dv[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Launch one op, measure latency, check result, then complete the handshake.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] exp;
    int         n;
    exp = ref_sub(a, b);
    n = 0;
    while (!ready_o && n < 40) begin tick(); n++; end
    opa_i = a; opb_i = b; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0; opa_i = $urandom; opb_i = $urandom;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL %s ready_after_accept got=%b exp=0", nm, ready_o); end
    n = 0;
    while (!valid_o && n < 40) begin tick(); n++; end
    checks++;
    if (n !== W) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", nm, n, W); end
    checks++;
    if (diff_o !== exp[W-1:0]) begin errors++; $display("FAIL %s diff got=%h exp=%h", nm, diff_o, exp[W-1:0]); end
    checks++;
    if (borrow_o !== exp[W]) begin errors++; $display("FAIL %s borrow got=%b exp=%b", nm, borrow_o, exp[W]); end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL %s return_idle got ready=%b valid=%b exp ready=1 valid=0", nm, ready_o, valid_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ready_o, valid_o, diff_o, borrow_o} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0}) begin
      errors++; $display("FAIL reset_values got ready=%b valid=%b diff=%h borrow=%b exp 1 0 00 0",
                         ready_o, valid_o, diff_o, borrow_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    run_op("c8_37", 8'hC8, 8'h37);
    run_op("05_0a", 8'h05, 8'h0A);
    run_op("ff_ff", 8'hFF, 8'hFF);
    run_op("00_01", 8'h00, 8'h01);
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    int         n;
    exp = ref_sub(8'h3C, 8'h5A);
    opa_i = 8'h3C; opb_i = 8'h5A; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      valid_i = ~valid_i; opa_i = $urandom; opb_i = $urandom;
      tick();
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || diff_o !== exp[W-1:0] || borrow_o !== exp[W]) begin
        errors++; $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b diff=%h borrow=%b exp 1 0 %h %b",
                           i, valid_o, ready_o, diff_o, borrow_o, exp[W-1:0], exp[W]);
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || diff_o !== exp[W-1:0] || borrow_o !== exp[W]) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b diff=%h borrow=%b exp 1 0 %h %b",
                         ready_o, valid_o, diff_o, borrow_o, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_mid_reset();
    bit rose;
    opa_i = 8'h80; opb_i = 8'h01; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, diff_o, borrow_o} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0}) begin
      errors++; $display("FAIL mid_reset_values got ready=%b valid=%b diff=%h borrow=%b exp 1 0 00 0",
                         ready_o, valid_o, diff_o, borrow_o);
    end
    rose = 1'b0;
    repeat (2) begin tick(); if (valid_o) rose = 1'b1; end
    rst_ni = 1'b1;
    repeat (12) begin tick(); if (valid_o) rose = 1'b1; end
    checks++;
    if (rose) begin errors++; $display("FAIL aborted_valid got=1 exp=0"); end
    run_op("after_reset_80_01", 8'h80, 8'h01);
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] exp;
    logic       acc, dlv;
    logic [W-1:0] a, b, d_s;
    logic       b_s;
    int         sent, got, cyc, bad;
    sent = 0; got = 0; cyc = 0; bad = 0;
    while (got < 200 && cyc < 20000) begin
      if (sent < 200 && ($urandom_range(0, 3) != 0)) begin
        a = $urandom; b = $urandom;
        valid_i = 1'b1; opa_i = a; opb_i = b;
      end else begin
        valid_i = 1'b0; opa_i = $urandom; opb_i = $urandom;
        a = opa_i; b = opb_i;
      end
      ready_i = ($urandom_range(0, 2) != 0);
      #1;
      acc = valid_i && ready_o;
      dlv = valid_o && ready_i;
      d_s = diff_o; b_s = borrow_o;
      tick();
      cyc++;
      if (acc) begin q.push_back(ref_sub(a, b)); sent++; end
      if (dlv) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL stream_dup got=%h/%b exp=none_pending", d_s, b_s);
        end else begin
          exp = q.pop_front();
          if ({b_s, d_s} !== exp) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL stream_result n=%0d got=%h/%b exp=%h/%b", got, d_s, b_s, exp[W-1:0], exp[W]);
          end
        end
      end
    end
    valid_i = 1'b0; ready_i = 1'b0;
    checks++;
    if (got != 200 || q.size() != 0) begin
      errors++; $display("FAIL stream_count got=%0d pending=%0d exp=200 pending=0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
